// File: rtl/seq_booth_multiplier_if.sv
// seq_booth_multiplier_if: start/operand request and busy/done/product response bundle.
interface seq_booth_multiplier_if #(parameter int WIDTH = 32);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: radix-2 Booth signed multiplier, one add/sub step per cycle
// through a parallel-prefix carry-lookahead adder.
module seq_booth_cla #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             pos_ovf_o,
    output logic             neg_ovf_o
);
    logic [WIDTH-1:0] gg, pp;
    logic [WIDTH:0]   c;
    always_comb begin
        gg = x_i & y_i;
        pp = x_i ^ y_i;
        for (int d = 1; d < WIDTH; d = d * 2)
            for (int i = WIDTH - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        c[0] = cin_i;
        for (int i = 0; i < WIDTH; i++) c[i+1] = gg[i] | (pp[i] & cin_i);
    end
    assign sum_o     = x_i ^ y_i ^ c[WIDTH-1:0];
    assign pos_ovf_o = ~x_i[WIDTH-1] & ~y_i[WIDTH-1] &  sum_o[WIDTH-1];
    assign neg_ovf_o =  x_i[WIDTH-1] &  y_i[WIDTH-1] & ~sum_o[WIDTH-1];
endmodule

module seq_booth_multiplier #(parameter int WIDTH = 32) (
    input  logic                 clk,
    input  logic                 rst,
    seq_booth_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d, a_q, a_d, q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     sum, s;
    logic                 pos_ovf, neg_ovf, add, sub, sign;
    assign add = q_q[0] ^ qm1_q;
    assign sub = q_q[0] & ~qm1_q;
    seq_booth_cla #(.WIDTH(WIDTH)) u_cla (
        .x_i(a_q), .y_i(sub ? ~m_q : m_q), .cin_i(sub),
        .sum_o(sum), .pos_ovf_o(pos_ovf), .neg_ovf_o(neg_ovf)
    );
    assign s = add ? sum : a_q;
    // Correcting the sign with overflow keeps the shifted-in bit exact even for M = MIN_INT.
    assign sign = add ? sum[WIDTH-1] ^ (pos_ovf | neg_ovf) : a_q[WIDTH-1];
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        if (state_q == RUN) begin
            a_d     = {sign, s[WIDTH-1:1]};
            q_d     = {s[0], q_q[WIDTH-1:1]};
            qm1_d   = q_q[0];
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == CW'(1) ? DONE : RUN;
            prod_d  = cnt_q == CW'(1) ? {a_d, q_d} : prod_q;
        end else if (bus.start) begin
            m_d     = bus.a;
            q_d     = bus.b;
            a_d     = '0;
            qm1_d   = 1'b0;
            cnt_d   = CW'(WIDTH);
            state_d = RUN;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end
    assign bus.busy    = state_q == RUN;
    assign bus.done    = state_q == DONE;
    assign bus.product = prod_q;
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: directed vectors with hand-computed products and timing checks.
module tb_seq_booth_multiplier;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tot = 0;
    int n_bad = 0;
    seq_booth_multiplier_if #(.WIDTH(W)) bus ();
    seq_booth_multiplier #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 1;
        busy_cnt = 0;
        while (!bus.done && cyc < 200) begin
            busy_cnt += int'(bus.busy);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
        int cyc, bc;
        launch(a, b);
        wait_done(cyc, bc);
        chk({tag, "_lat"}, 64'(cyc), 64'(W + 1));
        chk({tag, "_busy"}, 64'(bc), 64'(W));
        chk({tag, "_prod"}, bus.product, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int cyc, bc;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_prod", bus.product, 64'd0);
        rst = 1'b0;

        run("p3x5", 32'd3, 32'd5, 64'd15);
        repeat (5) @(negedge clk);
        chk("hold_idle", bus.product, 64'd15);
        run("m7x6", -32'sd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
        run("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run("minxm1", 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run("maxxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);

        // start while busy must be ignored
        launch(32'd2, 32'd3);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd9;
        bus.b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc, bc);
        chk("ign_lat", 64'(cyc + 5), 64'(W + 1));
        chk("ign_busy", 64'(bc + 5), 64'(W));
        chk("ign_prod", bus.product, 64'd6);
        @(negedge clk);
        bc = 0;
        repeat (W + 4) begin
            bc += int'(bus.done) + int'(bus.busy);
            @(negedge clk);
        end
        chk("ign_single", 64'(bc), 64'd0);

        // reset mid-run aborts
        launch(32'd123, 32'd456);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_prod", bus.product, 64'd0);
        bc = 0;
        repeat (W + 4) begin
            bc += int'(bus.done);
            @(negedge clk);
        end
        chk("abort_nodone", 64'(bc), 64'd0);
        run("p4xm4", 32'd4, -32'sd4, 64'hFFFF_FFFF_FFFF_FFF0);

        // back-to-back with start held high through DONE
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'hFFFF_FFFF;
        bus.b = 32'hFFFF_FFFF;
        @(negedge clk);
        wait_done(cyc, bc);
        chk("b2b1_lat", 64'(cyc), 64'(W + 1));
        chk("b2b1_prod", bus.product, 64'd1);
        bus.a = 32'd100;
        bus.b = 32'd50;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        chk("b2b_hold0", bus.product, 64'd1);
        repeat (W / 2) @(negedge clk);
        chk("b2b_hold1", bus.product, 64'd1);
        cyc = 1 + W / 2;
        while (!bus.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_gap", 64'(cyc), 64'(W + 1));
        chk("b2b2_prod", bus.product, 64'd5000);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
